// File: rtl/jtag_state_machine.sv
// JTAG TAP controller with a 5-bit instruction register chain.
// Latency: state and IR chain update one clock edge after TMS/TDI; IR outputs follow the chain combinationally.
// Backpressure: none; TMS/TDI are consumed on every rising edge of clock.
module jtag_state_machine (
    input  logic       clock,
    input  logic       reset,
    input  logic       io_tms,
    input  logic       io_tdi,
    output logic [3:0] io_currState,
    output logic       io_irChainOut_data,
    output logic [4:0] io_irUpdate_bits,
    output logic       io_irUpdate_valid
);

    // Encoding is fixed by the TAP definition; all 16 codes are live states.
    typedef enum logic [3:0] {
        stTLR     = 4'hF,
        stRTI     = 4'hC,
        stSelDR   = 4'h7,
        stCapDR   = 4'h6,
        stShDR    = 4'h2,
        stEx1DR   = 4'h1,
        stPauseDR = 4'h3,
        stEx2DR   = 4'h0,
        stUpdDR   = 4'h5,
        stSelIR   = 4'h4,
        stCapIR   = 4'hE,
        stShIR    = 4'hA,
        stEx1IR   = 4'h9,
        stPauseIR = 4'hB,
        stEx2IR   = 4'h8,
        stUpdIR   = 4'hD
    } tapState_t;

    tapState_t  currState;
    tapState_t  nextState;
    logic [4:0] irChain;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            currState <= stTLR;
        end else begin
            currState <= nextState;
        end
    end

    always_comb begin
        nextState = currState;
        case (currState)
            stTLR:     nextState = io_tms ? stTLR     : stRTI;
            stRTI:     nextState = io_tms ? stSelDR   : stRTI;
            stSelDR:   nextState = io_tms ? stSelIR   : stCapDR;
            stCapDR:   nextState = io_tms ? stEx1DR   : stShDR;
            stShDR:    nextState = io_tms ? stEx1DR   : stShDR;
            stEx1DR:   nextState = io_tms ? stUpdDR   : stPauseDR;
            stPauseDR: nextState = io_tms ? stEx2DR   : stPauseDR;
            stEx2DR:   nextState = io_tms ? stUpdDR   : stShDR;
            stUpdDR:   nextState = io_tms ? stSelDR   : stRTI;
            stSelIR:   nextState = io_tms ? stTLR     : stCapIR;
            stCapIR:   nextState = io_tms ? stEx1IR   : stShIR;
            stShIR:    nextState = io_tms ? stEx1IR   : stShIR;
            stEx1IR:   nextState = io_tms ? stUpdIR   : stPauseIR;
            stPauseIR: nextState = io_tms ? stEx2IR   : stPauseIR;
            stEx2IR:   nextState = io_tms ? stUpdIR   : stShIR;
            stUpdIR:   nextState = io_tms ? stSelDR   : stRTI;
            default:   nextState = stTLR;
        endcase
    end

    // Shift is keyed on the current state only, so the exit edge out of ShIR still shifts.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            irChain <= 5'b00000;
        end else begin
            case (currState)
                stCapIR: irChain <= 5'b00001;
                stShIR:  irChain <= {io_tdi, irChain[4:1]};
                default: irChain <= irChain;
            endcase
        end
    end

    assign io_currState       = currState;
    assign io_irChainOut_data = irChain[0];
    assign io_irUpdate_bits   = irChain;
    assign io_irUpdate_valid  = (currState == stUpdIR);

endmodule

// File: tb/tb_jtag_state_machine.sv
// Randomized and directed bench for jtag_state_machine; expected responses are queued
// by the stimulus process and compared by an independent monitor after each rising edge.
module tb_jtag_state_machine;

    logic       clock;
    logic       reset;
    logic       io_tms;
    logic       io_tdi;
    logic [3:0] io_currState;
    logic       io_irChainOut_data;
    logic [4:0] io_irUpdate_bits;
    logic       io_irUpdate_valid;

    jtag_state_machine dut (
        .clock              (clock),
        .reset              (reset),
        .io_tms             (io_tms),
        .io_tdi             (io_tdi),
        .io_currState       (io_currState),
        .io_irChainOut_data (io_irChainOut_data),
        .io_irUpdate_bits   (io_irUpdate_bits),
        .io_irUpdate_valid  (io_irUpdate_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam logic [3:0] TLR = 4'hF, RTI = 4'hC, SELDR = 4'h7, CAPDR = 4'h6, SHDR = 4'h2,
                           EX1DR = 4'h1, PAUSEDR = 4'h3, EX2DR = 4'h0, UPDDR = 4'h5,
                           SELIR = 4'h4, CAPIR = 4'hE, SHIR = 4'hA, EX1IR = 4'h9,
                           PAUSEIR = 4'hB, EX2IR = 4'h8, UPDIR = 4'hD;

    typedef struct packed {
        logic [3:0] state;
        logic [4:0] chain;
    } expect_t;

    expect_t    expQ[$];
    bit         pathQ[$];
    logic [3:0] mState;
    logic [4:0] mChain;
    int         nChecks = 0;
    int         nErrors = 0;

    task automatic chk(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transition table written out from the TAP diagram.
    function automatic logic [3:0] refNext(input logic [3:0] s, input bit t);
        case (s)
            TLR:     return t ? TLR     : RTI;
            RTI:     return t ? SELDR   : RTI;
            SELDR:   return t ? SELIR   : CAPDR;
            CAPDR:   return t ? EX1DR   : SHDR;
            SHDR:    return t ? EX1DR   : SHDR;
            EX1DR:   return t ? UPDDR   : PAUSEDR;
            PAUSEDR: return t ? EX2DR   : PAUSEDR;
            EX2DR:   return t ? UPDDR   : SHDR;
            UPDDR:   return t ? SELDR   : RTI;
            SELIR:   return t ? TLR     : CAPIR;
            CAPIR:   return t ? EX1IR   : SHIR;
            SHIR:    return t ? EX1IR   : SHIR;
            EX1IR:   return t ? UPDIR   : PAUSEIR;
            PAUSEIR: return t ? EX2IR   : PAUSEIR;
            EX2IR:   return t ? UPDIR   : SHIR;
            default: return t ? SELDR   : RTI;
        endcase
    endfunction

    // One clock of stimulus: inputs change on the falling edge, expectation queued for the next rise.
    task automatic step(input bit t, input bit d);
        @(negedge clock);
        io_tms = t;
        io_tdi = d;
        if (mState == CAPIR)
            mChain = 5'b00001;
        else if (mState == SHIR)
            mChain = (mChain >> 1) + (d ? 5'd16 : 5'd0);
        mState = refNext(mState, t);
        expQ.push_back('{state: mState, chain: mChain});
    endtask

    // Shortest TMS sequence from TLR to target, found by breadth-first search over the table.
    task automatic buildPath(input logic [3:0] target);
        int prevS[16];
        bit prevT[16];
        bit seen[16];
        int fr[$];
        int cur;
        logic [3:0] nx;
        pathQ.delete();
        seen[15] = 1'b1;
        fr.push_back(15);
        while (fr.size() > 0) begin
            cur = fr.pop_front();
            for (int b = 0; b < 2; b++) begin
                nx = refNext(4'(cur), b[0]);
                if (!seen[nx]) begin
                    seen[nx]  = 1'b1;
                    prevS[nx] = cur;
                    prevT[nx] = b[0];
                    fr.push_back(int'(nx));
                end
            end
        end
        cur = int'(target);
        while (cur != 15) begin
            pathQ.push_front(prevT[cur]);
            cur = prevS[cur];
        end
    endtask

    task automatic goTo(input logic [3:0] target);
        repeat (5) step(1'b1, 1'($urandom));
        buildPath(target);
        foreach (pathQ[i]) step(pathQ[i], 1'($urandom));
    endtask

    // Async reset between edges: the DUT must reach TLR with an empty chain before the next edge.
    task automatic asyncReset(input string tag);
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        chk({tag, "_state"}, io_currState, TLR);
        chk({tag, "_bits"}, io_irUpdate_bits, 0);
        chk({tag, "_valid"}, io_irUpdate_valid, 0);
        mState = TLR;
        mChain = 5'b00000;
        io_tms = 1'b1;
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Monitor: each rising edge with a pending expectation is checked 2 time units later.
    always @(posedge clock) begin
        expect_t e;
        #2;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            chk("state", io_currState, e.state);
            chk("bits", io_irUpdate_bits, e.chain);
            chk("chainOut", io_irChainOut_data, e.chain[0]);
            chk("valid", io_irUpdate_valid, (e.state == UPDIR) ? 1 : 0);
        end
    end

    initial begin
        int drain;
        reset  = 1'b0;
        io_tms = 1'b1;
        io_tdi = 1'b0;
        mState = TLR;
        mChain = 5'b00000;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_state", io_currState, TLR);
        chk("rst_bits", io_irUpdate_bits, 0);
        chk("rst_valid", io_irUpdate_valid, 0);
        chk("rst_out", io_irChainOut_data, 0);
        @(negedge clock);
        reset = 1'b1;

        // Enter ShIR, scan 1,0,1,1,0 out to Ex1IR, update, then return to RTI.
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("scan_model_bits", mChain, 5'h0D);

        // Into ShDR with a non-empty chain, then reset asynchronously.
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        asyncReset("async_shdr");

        // Every transition from every state, for both TMS values.
        for (int s = 0; s < 16; s++)
            for (int b = 0; b < 2; b++) begin
                goTo(4'(s));
                step(b[0], 1'($urandom));
            end

        // Five TMS=1 edges reach TLR from every state.
        for (int s = 0; s < 16; s++) begin
            goTo(4'(s));
            repeat (5) step(1'b1, 1'($urandom));
        end

        repeat (1500) step(($urandom_range(0, 2) == 0), 1'($urandom));

        goTo(SHIR);
        step(1'b0, 1'b1);
        asyncReset("async_shir");

        drain = 0;
        while (expQ.size() > 0 && drain < 10) begin
            @(posedge clock);
            drain++;
        end
        #3;
        chk("queue_drained", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/jtag_state_machine.md
JTAG_STATE_MACHINE -- requirements
Module: jtag_state_machine

Interface
REQ-001 The block SHALL have `clock`, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have `reset`, input, 1 bit, asynchronous, active-low (0 = reset asserted).
REQ-003 The block SHALL have `io_tms`, input, 1 bit, JTAG TMS, sampled on the rising edge of `clock`.
REQ-004 The block SHALL have `io_tdi`, input, 1 bit, JTAG TDI, serial data into the IR chain.
REQ-005 The block SHALL have `io_currState`, output, 4 bits, current TAP state, registered.
REQ-006 The block SHALL have `io_irChainOut_data`, output, 1 bit, the IR chain LSB (serial out toward TDO).
REQ-007 The block SHALL have `io_irUpdate_bits`, output, 5 bits, the current contents of the IR chain, combinational.
REQ-008 The block SHALL have `io_irUpdate_valid`, output, 1 bit, high while `io_currState` = UpdateIR.

Function
REQ-009 TAP state encoding SHALL be as follows:
- TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5.
- SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D.
REQ-010 Transitions SHALL be as follows, written as TMS=0 / TMS=1:
- TLR->RTI/TLR; RTI->RTI/SelDR; SelDR->CapDR/SelIR; CapDR->ShDR/Ex1DR; ShDR->ShDR/Ex1DR.
- Ex1DR->PauseDR/UpdDR; PauseDR->PauseDR/Ex2DR; Ex2DR->ShDR/UpdDR; UpdDR->RTI/SelDR.
- SelIR->CapIR/TLR; CapIR->ShIR/Ex1IR; ShIR->ShIR/Ex1IR; Ex1IR->PauseIR/UpdIR; PauseIR->PauseIR/Ex2IR; Ex2IR->ShIR/UpdIR; UpdIR->RTI/SelDR.
REQ-011 All 16 encodings SHALL be legal states; the block has no unreachable state.
REQ-012 Five consecutive rising edges with TMS=1 SHALL reach TLR from any state.
REQ-013 The IR chain SHALL be a 5-bit register, with bit 0 as the LSB.
REQ-014 On a rising edge while the state is CapIR, the IR chain SHALL load 5'b00001.
REQ-015 On a rising edge while the state is ShIR, the IR chain SHALL shift right by one: bit4 takes `io_tdi`, and bit n takes bit n+1.
REQ-016 The shift SHALL also occur on the edge that exits ShIR, including when TMS=1.
REQ-017 In all other states the IR chain SHALL hold its value.
REQ-018 `io_irChainOut_data` SHALL equal IR chain bit 0 at all times.
REQ-019 `io_irUpdate_valid` SHALL be a combinational decode of state UpdIR, with no extra latency.
REQ-020 `io_irUpdate_bits` SHALL equal the IR chain contents at all times; the chain is not modified in UpdIR.
REQ-021 The DR path SHALL be external; this block only reports states ShDR/CapDR/UpdDR through `io_currState`.
REQ-022 If a shift and a capture fall on the same edge, state exclusivity SHALL resolve it: exactly one of CapIR, ShIR, or hold applies per edge.

Reset
REQ-023 While `reset`=0, the state SHALL immediately be TLR (F), independent of `clock`.
REQ-024 While `reset`=0, the IR chain SHALL be 5'b00000.
REQ-025 While `reset`=0, `io_irUpdate_valid` SHALL be 0.
REQ-026 Reset asserted mid-scan (for example in ShIR) SHALL abort to TLR at once, and the chain contents SHALL be lost.
REQ-027 After `reset` deasserts, the first rising edge SHALL follow REQ-010 starting from TLR.

Verification
REQ-028 The bench SHALL drive `reset`=0 for 2 cycles and then release it; the required response is `io_currState`=F and `io_irUpdate_bits`=00000.
REQ-029 From TLR, the bench SHALL apply TMS 0,1,1,0,0; the states SHALL be C, 7, 4, E, A, and `io_irUpdate_bits`=00001 once ShIR is entered.
REQ-030 In ShIR, the bench SHALL apply TDI 1,0,1,1,0 with TMS 0,0,0,0,1.
REQ-031 For the REQ-030 stimulus, `io_irChainOut_data` before each edge SHALL read 1,0,0,0,0, and the final state SHALL be 9 with bits=0x0D.
REQ-032 Following REQ-030, the bench SHALL apply TMS=1; the state SHALL be D, `io_irUpdate_valid`=1, and bits=0x0D.
REQ-033 The bench SHALL then apply TMS=0; the state SHALL be C and valid=0.
REQ-034 The bench SHALL walk through every transition in REQ-010 for both TMS values; every next state SHALL match.
REQ-035 From each of the 16 states, the bench SHALL apply 5×TMS=1; the state SHALL be F.
REQ-036 The bench SHALL assert `reset`=0 asynchronously between clock edges while in ShDR (2); `io_currState` SHALL become F before the next edge, and the chain SHALL read 00000.
